// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_unit
// Brief    : Moore-FSM controller for a shared-memory multicycle MIPS datapath,
//            with memory wait states, optional timeout and sticky fault.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control_unit #(
    parameter int ULA_CTRL_W   = 3,
    parameter int MEM_TIMEOUT  = 0,
    parameter bit ENABLE_FAULT = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [5:0]            OP,
    input  logic [5:0]            Funct,
    input  logic                  MemReady,
    output logic                  PCWrite,
    output logic                  Branch,
    output logic                  BranchNE,
    output logic                  IorD,
    output logic                  MemRead,
    output logic                  MemWrite,
    output logic                  IRWrite,
    output logic                  MemtoReg,
    output logic                  RegDst,
    output logic                  RegWrite,
    output logic                  ULASrcA,
    output logic [1:0]            ULASrcB,
    output logic                  ZeroExt,
    output logic [1:0]            PCSrc,
    output logic [ULA_CTRL_W-1:0] ULAControl,
    output logic                  Fault,
    output logic                  FaultCause,
    output logic [3:0]            State
);

    typedef enum logic [3:0] {
        S_RESET    = 4'd0,  S_FETCH   = 4'd1,  S_DECODE = 4'd2,  S_MEMADR = 4'd3,
        S_MEMREAD  = 4'd4,  S_MEMWB   = 4'd5,  S_MEMWRITE = 4'd6, S_EXECUTE = 4'd7,
        S_ALUWB    = 4'd8,  S_IEXEC   = 4'd9,  S_IWB    = 4'd10, S_BRANCH = 4'd11,
        S_JUMP     = 4'd12, S_FAULT   = 4'd13
    } state_t;

    typedef enum logic [2:0] {
        CLS_RTYPE, CLS_LW, CLS_SW, CLS_IALU, CLS_BEQ, CLS_BNE, CLS_JUMP, CLS_ILLEGAL
    } class_t;

    localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam bit TIMEOUT_EN = (MEM_TIMEOUT > 0) && ENABLE_FAULT;

    localparam logic [ULA_CTRL_W-1:0] ULA_ADD = ULA_CTRL_W'(3'b010);
    localparam logic [ULA_CTRL_W-1:0] ULA_SUB = ULA_CTRL_W'(3'b110);
    localparam logic [ULA_CTRL_W-1:0] ULA_AND = ULA_CTRL_W'(3'b000);
    localparam logic [ULA_CTRL_W-1:0] ULA_OR  = ULA_CTRL_W'(3'b001);
    localparam logic [ULA_CTRL_W-1:0] ULA_SLT = ULA_CTRL_W'(3'b111);
    localparam logic [ULA_CTRL_W-1:0] ULA_NOR = ULA_CTRL_W'(3'b011);
    localparam logic [ULA_CTRL_W-1:0] ULA_XOR = ULA_CTRL_W'(3'b100);

    state_t                  state, state_next;
    class_t                  cls, dec_cls;
    logic [ULA_CTRL_W-1:0]   alu_sel, dec_alu;
    logic                    zext, dec_zext;
    logic [CNT_W-1:0]        wait_cnt;
    logic                    fault_cause;
    logic                    mem_wait, timed_out;

    // Instruction classification; only consumed while in DECODE.
    always_comb begin
        dec_cls  = CLS_ILLEGAL;
        dec_alu  = ULA_ADD;
        dec_zext = 1'b0;
        case (OP)
            6'b000000: begin
                dec_cls = CLS_RTYPE;
                case (Funct)
                    6'b100000: dec_alu = ULA_ADD;
                    6'b100010: dec_alu = ULA_SUB;
                    6'b100100: dec_alu = ULA_AND;
                    6'b100101: dec_alu = ULA_OR;
                    6'b101010: dec_alu = ULA_SLT;
                    6'b100111: dec_alu = ULA_NOR;
                    6'b100110: dec_alu = ULA_XOR;
                    default:   dec_cls = CLS_ILLEGAL;
                endcase
            end
            6'b100011: dec_cls = CLS_LW;
            6'b101011: dec_cls = CLS_SW;
            6'b001000: begin dec_cls = CLS_IALU; dec_alu = ULA_ADD; end
            6'b001100: begin dec_cls = CLS_IALU; dec_alu = ULA_AND; dec_zext = 1'b1; end
            6'b001101: begin dec_cls = CLS_IALU; dec_alu = ULA_OR;  dec_zext = 1'b1; end
            6'b001010: begin dec_cls = CLS_IALU; dec_alu = ULA_SLT; end
            6'b001110: begin dec_cls = CLS_IALU; dec_alu = ULA_XOR; dec_zext = 1'b1; end
            6'b000100: dec_cls = CLS_BEQ;
            6'b000101: dec_cls = CLS_BNE;
            6'b000010: dec_cls = CLS_JUMP;
            default:   dec_cls = CLS_ILLEGAL;
        endcase
    end

    assign mem_wait  = ((state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE))
                       && !MemReady;
    assign timed_out = TIMEOUT_EN && mem_wait && (wait_cnt == CNT_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_RESET;
            cls         <= CLS_ILLEGAL;
            alu_sel     <= ULA_ADD;
            zext        <= 1'b0;
            wait_cnt    <= '0;
            fault_cause <= 1'b0;
        end else begin
            state <= state_next;
            if (state == S_DECODE) begin
                cls     <= dec_cls;
                alu_sel <= dec_alu;
                zext    <= dec_zext;
            end
            if (state_next != state) begin
                wait_cnt <= '0;
            end else if (mem_wait && (wait_cnt != CNT_MAX)) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
            // Only a timeout can fault from a memory state; DECODE faults are illegal opcodes.
            if ((state_next == S_FAULT) && (state != S_FAULT)) begin
                fault_cause <= timed_out;
            end
        end
    end

    always_comb begin
        state_next = state;
        PCWrite    = 1'b0;
        Branch     = 1'b0;
        BranchNE   = 1'b0;
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        MemtoReg   = 1'b0;
        RegDst     = 1'b0;
        RegWrite   = 1'b0;
        ULASrcA    = 1'b0;
        ULASrcB    = 2'b00;
        ZeroExt    = 1'b0;
        PCSrc      = 2'b00;
        ULAControl = '0;
        case (state)
            S_RESET: state_next = S_FETCH;
            S_FETCH: begin
                MemRead    = 1'b1;
                ULASrcB    = 2'b01;
                ULAControl = ULA_ADD;
                IRWrite    = MemReady;
                PCWrite    = MemReady;
                if (MemReady)       state_next = S_DECODE;
                else if (timed_out) state_next = S_FAULT;
            end
            S_DECODE: begin
                ULASrcB    = 2'b11;
                ULAControl = ULA_ADD;
                case (dec_cls)
                    CLS_RTYPE:       state_next = S_EXECUTE;
                    CLS_LW, CLS_SW:  state_next = S_MEMADR;
                    CLS_IALU:        state_next = S_IEXEC;
                    CLS_BEQ, CLS_BNE: state_next = S_BRANCH;
                    CLS_JUMP:        state_next = S_JUMP;
                    default: begin
                        if (ENABLE_FAULT) state_next = S_FAULT;
                        else              state_next = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ULASrcA    = 1'b1;
                ULASrcB    = 2'b10;
                ULAControl = ULA_ADD;
                if (cls == CLS_LW) state_next = S_MEMREAD;
                else               state_next = S_MEMWRITE;
            end
            S_MEMREAD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
                if (MemReady)       state_next = S_MEMWB;
                else if (timed_out) state_next = S_FAULT;
            end
            S_MEMWB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                if (MemReady)       state_next = S_FETCH;
                else if (timed_out) state_next = S_FAULT;
            end
            S_EXECUTE: begin
                ULASrcA    = 1'b1;
                ULAControl = alu_sel;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                RegDst     = 1'b1;
                RegWrite   = 1'b1;
                state_next = S_FETCH;
            end
            S_IEXEC: begin
                ULASrcA    = 1'b1;
                ULASrcB    = 2'b10;
                ULAControl = alu_sel;
                ZeroExt    = zext;
                state_next = S_IWB;
            end
            S_IWB: begin
                RegWrite   = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                ULASrcA    = 1'b1;
                ULAControl = ULA_SUB;
                PCSrc      = 2'b01;
                Branch     = (cls == CLS_BEQ);
                BranchNE   = (cls == CLS_BNE);
                state_next = S_FETCH;
            end
            S_JUMP: begin
                PCSrc      = 2'b10;
                PCWrite    = 1'b1;
                state_next = S_FETCH;
            end
            S_FAULT: state_next = S_FAULT;
            default: state_next = S_RESET;
        endcase
    end

    assign Fault      = (state == S_FAULT);
    assign FaultCause = fault_cause;
    assign State      = state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control_unit
// Brief    : Directed bench for three controller configurations against a
//            cycle-level behavioural model plus literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_control_unit;

    localparam int N = 3;  // 0: default, 1: faults disabled, 2: timeout of 4
    localparam int ST_RESET = 0, ST_FETCH = 1, ST_DECODE = 2, ST_MEMADR = 3, ST_MEMREAD = 4,
                   ST_MEMWB = 5, ST_MEMWRITE = 6, ST_EXECUTE = 7, ST_ALUWB = 8, ST_IEXEC = 9,
                   ST_IWB = 10, ST_BRANCH = 11, ST_JUMP = 12, ST_FAULT = 13;
    localparam int K_R = 0, K_LW = 1, K_SW = 2, K_I = 3, K_BEQ = 4, K_BNE = 5, K_J = 6, K_BAD = 7;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] op = '0;
    logic [5:0] funct = '0;
    logic       mem_ready = 1'b0;

    logic [N-1:0] pc_write, branch, branch_ne, ior_d, mem_read, mem_write, ir_write;
    logic [N-1:0] mem_to_reg, reg_dst, reg_write, ula_src_a, zero_ext, fault, fault_cause;
    logic [1:0]   ula_src_b [N];
    logic [1:0]   pc_src    [N];
    logic [2:0]   ula_ctrl  [N];
    logic [3:0]   state     [N];

    int n_checks;
    int n_fail;

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < N; g++) begin : g_dut
            multicycle_control_unit #(
                .ULA_CTRL_W  (3),
                .MEM_TIMEOUT ((g == 2) ? 4 : 0),
                .ENABLE_FAULT((g == 1) ? 1'b0 : 1'b1)
            ) u_dut (
                .clk(clk), .rst_n(rst_n), .OP(op), .Funct(funct), .MemReady(mem_ready),
                .PCWrite(pc_write[g]), .Branch(branch[g]), .BranchNE(branch_ne[g]),
                .IorD(ior_d[g]), .MemRead(mem_read[g]), .MemWrite(mem_write[g]),
                .IRWrite(ir_write[g]), .MemtoReg(mem_to_reg[g]), .RegDst(reg_dst[g]),
                .RegWrite(reg_write[g]), .ULASrcA(ula_src_a[g]), .ULASrcB(ula_src_b[g]),
                .ZeroExt(zero_ext[g]), .PCSrc(pc_src[g]), .ULAControl(ula_ctrl[g]),
                .Fault(fault[g]), .FaultCause(fault_cause[g]), .State(state[g])
            );
        end
    endgenerate

    // ---------------- behavioural model ----------------
    int         m_state [N];
    int         m_wc    [N];
    logic       m_fc    [N];
    logic [5:0] m_op    [N];
    logic [5:0] m_fn    [N];

    function automatic int cfg_timeout(int i); return (i == 2) ? 4 : 0; endfunction
    function automatic bit cfg_fault(int i);   return (i != 1);         endfunction

    function automatic int r_alu(logic [5:0] f);
        case (f)
            6'b100000: return 2;  6'b100010: return 6;  6'b100100: return 0;
            6'b100101: return 1;  6'b101010: return 7;  6'b100111: return 3;
            6'b100110: return 4;  default:   return -1;
        endcase
    endfunction

    function automatic int i_alu(logic [5:0] o);
        case (o)
            6'b001000: return 2;  6'b001100: return 0;  6'b001101: return 1;
            6'b001010: return 7;  6'b001110: return 4;  default:   return -1;
        endcase
    endfunction

    function automatic int kind(logic [5:0] o, logic [5:0] f);
        if (o == 6'b000000) return (r_alu(f) >= 0) ? K_R : K_BAD;
        case (o)
            6'b100011: return K_LW;
            6'b101011: return K_SW;
            6'b000100: return K_BEQ;
            6'b000101: return K_BNE;
            6'b000010: return K_J;
            default:   return (i_alu(o) >= 0) ? K_I : K_BAD;
        endcase
    endfunction

    function automatic bit mem_phase(int i);
        return m_state[i] == ST_FETCH || m_state[i] == ST_MEMREAD || m_state[i] == ST_MEMWRITE;
    endfunction

    function automatic bit gives_up(int i);
        return cfg_timeout(i) > 0 && cfg_fault(i) && m_wc[i] == cfg_timeout(i) && !mem_ready;
    endfunction

    function automatic int next_state(int i);
        int k;
        case (m_state[i])
            ST_RESET:    return ST_FETCH;
            ST_FETCH:    return mem_ready ? ST_DECODE : (gives_up(i) ? ST_FAULT : ST_FETCH);
            ST_DECODE: begin
                k = kind(op, funct);
                if (k == K_R) return ST_EXECUTE;
                if (k == K_LW || k == K_SW) return ST_MEMADR;
                if (k == K_I) return ST_IEXEC;
                if (k == K_BEQ || k == K_BNE) return ST_BRANCH;
                if (k == K_J) return ST_JUMP;
                return cfg_fault(i) ? ST_FAULT : ST_FETCH;
            end
            ST_MEMADR:   return (m_op[i] == 6'b100011) ? ST_MEMREAD : ST_MEMWRITE;
            ST_MEMREAD:  return mem_ready ? ST_MEMWB : (gives_up(i) ? ST_FAULT : ST_MEMREAD);
            ST_MEMWRITE: return mem_ready ? ST_FETCH : (gives_up(i) ? ST_FAULT : ST_MEMWRITE);
            ST_EXECUTE:  return ST_ALUWB;
            ST_IEXEC:    return ST_IWB;
            ST_FAULT:    return ST_FAULT;
            default:     return ST_FETCH;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                m_state[i] <= ST_RESET;
                m_wc[i]    <= 0;
                m_fc[i]    <= 1'b0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                m_state[i] <= next_state(i);
                if (next_state(i) != m_state[i]) m_wc[i] <= 0;
                else if (mem_phase(i) && !mem_ready) m_wc[i] <= m_wc[i] + 1;
                if (m_state[i] == ST_DECODE) begin
                    m_op[i] <= op;
                    m_fn[i] <= funct;
                end
                if (next_state(i) == ST_FAULT && m_state[i] != ST_FAULT)
                    m_fc[i] <= (m_state[i] != ST_DECODE);
            end
        end
    end

    function automatic logic [24:0] exp_vec(int i);
        logic pcw = 0, br = 0, bne = 0, iod = 0, mr = 0, mw = 0, irw = 0;
        logic m2r = 0, rd = 0, rw = 0, sa = 0, ze = 0, flt = 0;
        logic [1:0] sb = 0, ps = 0;
        logic [2:0] alu = 0;
        case (m_state[i])
            ST_FETCH:    begin mr = 1; sb = 2'b01; alu = 3'b010; irw = mem_ready; pcw = mem_ready; end
            ST_DECODE:   begin sb = 2'b11; alu = 3'b010; end
            ST_MEMADR:   begin sa = 1; sb = 2'b10; alu = 3'b010; end
            ST_MEMREAD:  begin iod = 1; mr = 1; end
            ST_MEMWB:    begin rw = 1; m2r = 1; end
            ST_MEMWRITE: begin iod = 1; mw = 1; end
            ST_EXECUTE:  begin sa = 1; alu = 3'(r_alu(m_fn[i])); end
            ST_ALUWB:    begin rd = 1; rw = 1; end
            ST_IEXEC: begin
                sa = 1; sb = 2'b10; alu = 3'(i_alu(m_op[i]));
                ze = (m_op[i] == 6'b001100) || (m_op[i] == 6'b001101) || (m_op[i] == 6'b001110);
            end
            ST_IWB:      rw = 1;
            ST_BRANCH: begin
                sa = 1; alu = 3'b110; ps = 2'b01;
                br = (m_op[i] == 6'b000100); bne = (m_op[i] == 6'b000101);
            end
            ST_JUMP:     begin ps = 2'b10; pcw = 1; end
            ST_FAULT:    flt = 1;
            default: ;
        endcase
        return {pcw, br, bne, iod, mr, mw, irw, m2r, rd, rw, sa, sb, ze, ps, alu, flt, m_fc[i],
                4'(m_state[i])};
    endfunction

    function automatic logic [24:0] got_vec(int i);
        return {pc_write[i], branch[i], branch_ne[i], ior_d[i], mem_read[i], mem_write[i],
                ir_write[i], mem_to_reg[i], reg_dst[i], reg_write[i], ula_src_a[i],
                ula_src_b[i], zero_ext[i], pc_src[i], ula_ctrl[i], fault[i], fault_cause[i],
                state[i]};
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (got_vec(i) !== exp_vec(i)) begin
                n_fail++;
                $display("FAIL model_cmp dut%0d t=%0t got=%h expected=%h", i, $time,
                         got_vec(i), exp_vec(i));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, actual, expected);
        end
    endtask

    logic [5:0] t_op  [14] = '{6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000,
                               6'b001000, 6'b001100, 6'b001010, 6'b001110, 6'b000100, 6'b000010,
                               6'b101011, 6'b100011};
    logic [5:0] t_fn  [14] = '{6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111, 6'b100110,
                               6'b100000, 6'b100000, 6'b100000, 6'b100000, 6'b100000, 6'b100000,
                               6'b100000, 6'b100000};
    int         t_cyc [14] = '{4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 3, 3, 4, 5};

    initial begin
        n_checks = 0;
        n_fail   = 0;
        tick();
        tick();
        check("reset_state", state[0], ST_RESET);
        check("reset_outputs", {pc_write[0], mem_read[0], ir_write[0], reg_write[0], fault[0]}, 0);

        // ADD
        op = 6'b000000; funct = 6'b100000; mem_ready = 1'b1; rst_n = 1'b1;
        tick(); check("add_fetch", state[0], ST_FETCH); check("add_irwrite", ir_write[0], 1);
        tick(); check("add_decode_srcb", ula_src_b[0], 2'b11);
        tick(); check("add_execute", state[0], ST_EXECUTE); check("add_ulactrl", ula_ctrl[0], 3'b010);
        check("add_exec_regwrite", reg_write[0], 0);
        tick(); check("add_aluwb", {state[0], reg_write[0], reg_dst[0]}, {4'd8, 2'b11});
        tick(); check("add_back_fetch", state[0], ST_FETCH);

        // LW with three MemReady=0 cycles in MEMREAD
        op = 6'b100011;
        tick();
        tick(); check("lw_memadr", state[0], ST_MEMADR);
        mem_ready = 1'b0;
        tick(); check("lw_memread_strobes", {state[0], ior_d[0], mem_read[0]}, {4'd4, 2'b11});
        tick(); tick(); tick();
        check("lw_memread_4th", state[0], ST_MEMREAD);
        mem_ready = 1'b1;
        tick(); check("lw_memwb", {state[0], mem_to_reg[0], reg_write[0]}, {4'd5, 2'b11});
        tick();

        // BNE
        op = 6'b000101;
        tick(); tick();
        check("bne_branch", {state[0], branch_ne[0], branch[0], pc_src[0], ula_ctrl[0]},
              {4'd11, 1'b1, 1'b0, 2'b01, 3'b110});
        tick(); check("bne_back_fetch", state[0], ST_FETCH);

        // ORI
        op = 6'b001101;
        tick(); tick();
        check("ori_iexec", {state[0], zero_ext[0], ula_ctrl[0]}, {4'd9, 1'b1, 3'b001});
        tick(); tick(); check("ori_back_fetch", state[0], ST_FETCH);

        // Instruction fetch with wait states
        op = 6'b000000; funct = 6'b100000; mem_ready = 1'b0;
        tick(); check("fetch_wait", {state[0], ir_write[0], pc_write[0]}, {4'd1, 2'b00});
        tick(); mem_ready = 1'b1;
        tick(); check("fetch_wait_done", state[0], ST_DECODE);
        tick(); tick(); tick();

        // Remaining instruction mix with MemReady high: latency pins
        for (int k = 0; k < 14; k++) begin
            op = t_op[k]; funct = t_fn[k];
            repeat (t_cyc[k]) tick();
            check($sformatf("latency_%0d", k), state[0], ST_FETCH);
        end

        // Illegal opcode
        op = 6'b111111;
        tick(); tick();
        check("illegal_fault", {state[0], fault[0], fault_cause[0], mem_read[0]}, {4'd13, 3'b100});
        check("illegal_nop_cfg", state[1], ST_FETCH);
        repeat (3) tick();
        check("illegal_sticky", {state[0], mem_read[0], ir_write[0], pc_write[0]}, {4'd13, 3'b000});
        rst_n = 1'b0;
        tick(); check("illegal_reset_clears", {state[0], fault[0]}, {4'd0, 1'b0});

        // SW with MemReady held low: timeout on config 2
        op = 6'b101011; mem_ready = 1'b1; rst_n = 1'b1;
        tick(); tick(); tick();
        mem_ready = 1'b0;
        tick(); check("sw_memwrite", {state[2], mem_write[2]}, {4'd6, 1'b1});
        repeat (4) tick();
        check("sw_count_at_limit", state[2], ST_MEMWRITE);
        tick();
        check("sw_timeout_fault", {state[2], fault[2], fault_cause[2]}, {4'd13, 2'b11});
        check("sw_no_timeout_cfg0", {state[0], mem_write[0]}, {4'd6, 1'b1});

        // Asynchronous reset mid-MEMWRITE
        rst_n = 1'b0;
        #1;
        check("async_reset_memwrite", {state[0], mem_write[0]}, {4'd0, 1'b0});
        tick(); check("async_reset_hold", state[0], ST_RESET);
        op = 6'b101011; mem_ready = 1'b1; rst_n = 1'b1;
        tick(); check("after_reset_fetch", state[0], ST_FETCH);

        // MemReady arrives exactly when the count hits the limit
        tick(); tick();
        mem_ready = 1'b0;
        tick(); repeat (3) tick();
        check("boundary_waiting", state[2], ST_MEMWRITE);
        tick();
        mem_ready = 1'b1;
        tick(); check("boundary_no_fault", {state[2], fault[2]}, {4'd1, 1'b0});

        // Jump
        op = 6'b000010;
        tick(); tick();
        check("jump", {state[0], pc_write[0], pc_src[0]}, {4'd12, 1'b1, 2'b10});
        tick(); check("jump_back_fetch", state[0], ST_FETCH);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multicycle successor to the single-cycle MIPS control decoder.
- Sequences each instruction through fetch, decode, execute, memory and writeback states with a Moore FSM.
- Drives the shared-memory multicycle datapath: PC, IR, register file, ULA, and a unified instruction/data memory with a ready handshake.
- Adds behaviour the combinational decoder lacks: memory wait states, a memory timeout, and a sticky illegal-instruction fault.

Parameters:
- ULA_CTRL_W, 3, ULAControl width. Encodings: 010 add, 110 sub, 000 and, 001 or, 111 slt, 011 nor, 100 xor.
- MEM_TIMEOUT, 0, max consecutive MemReady=0 cycles tolerated in a memory state; 0 disables the timeout.
- ENABLE_FAULT, 1, 1 = illegal opcode or timeout enters FAULT; 0 = illegal opcode is treated as NOP and the timeout is ignored.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- OP  in  6  IR[31:26], stable from the cycle after IRWrite
- Funct  in  6  IR[5:0]
- MemReady  in  1  memory access completes this cycle
- PCWrite  out  1  unconditional PC load
- Branch  out  1  PC load if ULA Zero
- BranchNE  out  1  PC load if !Zero
- IorD  out  1  0 = PC addresses memory, 1 = ALUOut addresses memory
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register load
- MemtoReg  out  1  write-back data select: 1 = memory data register
- RegDst  out  1  destination register: 1 = rd, 0 = rt
- RegWrite  out  1  register file write enable
- ULASrcA  out  1  0 = PC, 1 = register A
- ULASrcB  out  2  00 = register B, 01 = constant 4, 10 = extended immediate, 11 = extended immediate << 2
- ZeroExt  out  1  zero-extend (rather than sign-extend) the immediate
- PCSrc  out  2  00 = ULA result, 01 = ALUOut, 10 = jump target
- ULAControl  out  ULA_CTRL_W  ULA operation
- Fault  out  1  sticky fault flag
- FaultCause  out  1  0 = illegal instruction, 1 = memory timeout
- State  out  4  current state, for debug

Behaviour:
- States: RESET, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTE, ALUWB, IEXEC, IWB, BRANCH, JUMP, FAULT.
- Outputs are decoded from the registered state plus the instruction class latched in DECODE. Any output not listed for a state is 0.
- rst_n low: state forced to RESET immediately; all outputs 0; wait counter cleared; Fault cleared. This applies mid-instruction, including during a pending memory access.
- RESET: all outputs 0; next state FETCH.
- FETCH:
  - Outputs: MemRead=1, IorD=0, ULASrcA=0, ULASrcB=01, ULAControl=010, PCSrc=00.
  - IRWrite = PCWrite = MemReady.
  - Stays in FETCH until MemReady=1, then goes to DECODE.
- DECODE:
  - Outputs: ULASrcA=0, ULASrcB=11, ULAControl=010 (branch target into ALUOut).
  - Latches the instruction class from OP/Funct.
  - R-type Funct 100000/100010/100100/100101/101010/100111/100110 -> EXECUTE.
  - OP 100011 or 101011 -> MEMADR.
  - OP 001000/001100/001101/001010/001110 -> IEXEC.
  - OP 000100 or 000101 -> BRANCH.
  - OP 000010 -> JUMP.
  - Anything else -> FAULT (FaultCause=0) if ENABLE_FAULT, otherwise FETCH.
- MEMADR: ULASrcA=1, ULASrcB=10, ULAControl=010; next state MEMREAD for LW, MEMWRITE for SW.
- MEMREAD: IorD=1, MemRead=1; waits for MemReady, then MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0; next state FETCH.
- MEMWRITE: IorD=1, MemWrite=1, held until MemReady; then FETCH.
- EXECUTE: ULASrcA=1, ULASrcB=00, ULAControl per Funct (add, sub, and, or, slt, nor, xor); next state ALUWB.
- ALUWB: RegDst=1, RegWrite=1; next state FETCH.
- IEXEC: ULASrcA=1, ULASrcB=10, ULAControl per OP (addi 010, andi 000, ori 001, slti 111, xori 100). ZeroExt=1 for andi, ori, xori. Next state IWB.
- IWB: RegDst=0, RegWrite=1; next state FETCH.
- BRANCH: ULASrcA=1, ULASrcB=00, ULAControl=110, PCSrc=01; Branch=1 for BEQ, BranchNE=1 for BNE; next state FETCH.
- JUMP: PCSrc=10, PCWrite=1; next state FETCH.
- FAULT: all control outputs 0, Fault=1; stays in FAULT until reset.
- Latency with MemReady tied high, in cycles: R-type 4, I-ALU 4, LW 5, SW 4, BEQ/BNE 3, J 3.
- Wait counter:
  - Width clog2(MEM_TIMEOUT+1), minimum 1 bit.
  - Increments on each MemReady=0 cycle in FETCH, MEMREAD or MEMWRITE; saturates, never wraps.
  - Clears on any state change.
  - When MEM_TIMEOUT>0, ENABLE_FAULT=1 and the count reaches MEM_TIMEOUT with MemReady still 0, the next state is FAULT with FaultCause=1.
  - MemReady=1 in the same cycle the count reaches MEM_TIMEOUT completes the access normally; no fault.
- MemReady is ignored outside FETCH, MEMREAD and MEMWRITE.

Test Plan:
- Reset, then ADD (OP=000000, Funct=100000) with MemReady=1 -> states RESET, FETCH, DECODE, EXECUTE, ALUWB, FETCH; ULAControl=010 in EXECUTE; RegWrite=RegDst=1 only in ALUWB.
- LW (OP=100011) with MemReady low for 3 cycles in MEMREAD, MEM_TIMEOUT=0 -> MEMREAD held 4 cycles with IorD=MemRead=1; then MEMWB with MemtoReg=RegWrite=1.
- BNE (OP=000101) -> 3-cycle sequence; in BRANCH: BranchNE=1, Branch=0, PCSrc=01, ULAControl=110. ORI (OP=001101) -> ZeroExt=1 and ULAControl=001 in IEXEC.
- OP=111111 with ENABLE_FAULT=1 -> FAULT after DECODE; Fault=1, FaultCause=0, all strobes 0 until reset. Same stimulus with ENABLE_FAULT=0 -> returns to FETCH.
- MEM_TIMEOUT=4, SW with MemReady held 0 -> FAULT with FaultCause=1 after 4 wait cycles. MemReady=1 on the 4th wait cycle -> FETCH, no fault.
- rst_n pulsed low while in MEMWRITE -> MemWrite=0 asynchronously before the next clock edge; after release: RESET, then FETCH.
